// File: rtl/mdu_pkg.sv
// mdu_pkg: op and state encodings shared by the multiply/divide unit
package mdu_pkg;
    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } t_mdu_op;

    typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} t_mdu_state;
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step on unsigned magnitudes
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] new_rem,
    output logic            quot_bit
);
    logic [XLEN:0] shifted, diff;

    assign shifted  = {rem, next_bit};
    assign diff     = shifted - {1'b0, divisor};
    // rem < divisor on entry, so a non-negative difference always fits in XLEN bits
    assign quot_bit = !diff[XLEN];
    assign new_rem  = quot_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit; MDU_FAST_MUL_EN selects a single-cycle multiplier
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] mdu_in1,
    input  logic [XLEN-1:0] mdu_in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_out,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    t_mdu_state        state, state_nxt;
    t_mdu_op           op, op_in;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   d, mag1, mag2, rem_nxt, result, fast_res;
    logic [2*XLEN-1:0] prod, prod_nxt, w, ws;
    logic [XLEN:0]     sum;
    logic              neg, neg_in, s1, s2, q_bit, accept, fast;

    assign op_in  = t_mdu_op'(mdu_op);
    assign accept = in_valid && in_ready;
    assign s1     = mdu_in1[XLEN-1] && (op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
    assign s2     = mdu_in2[XLEN-1] && (op_in inside {MDU_MULH, MDU_DIV, MDU_REM});
    assign mag1   = s1 ? -mdu_in1 : mdu_in1;
    assign mag2   = s2 ? -mdu_in2 : mdu_in2;
    // a zero divisor keeps the all-ones quotient un-negated
    assign neg_in = (op_in == MDU_MULH) ? s1 ^ s2 :
                    (op_in == MDU_MULHSU || op_in == MDU_REM) ? s1 :
                    (op_in == MDU_DIV) ? (s1 ^ s2) && |mdu_in2 : 1'b0;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_p;
    assign fast_p   = {{XLEN{s1}}, mdu_in1} * {{XLEN{s2}}, mdu_in2};
    assign fast     = !op_in[2];
    assign fast_res = (op_in == MDU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem      (prod[2*XLEN-1:XLEN]),
        .next_bit (prod[XLEN-1]),
        .divisor  (d),
        .new_rem  (rem_nxt),
        .quot_bit (q_bit)
    );

    // multiply: shift-add right into the high half; divide: {remainder, dividend/quotient}
    assign sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, d} : '0);
    assign prod_nxt = op[2] ? {rem_nxt, prod[XLEN-2:0], q_bit} : {sum, prod[XLEN-1:1]};
    assign w        = op[2] ? {op[1] ? prod_nxt[2*XLEN-1:XLEN] : prod_nxt[XLEN-1:0], {XLEN{1'b0}}}
                            : prod_nxt;
    assign ws       = neg ? -w : w;
    assign result   = (op == MDU_MUL) ? ws[XLEN-1:0] : ws[2*XLEN-1:XLEN];

    always_comb begin
        in_ready  = state == MDU_IDLE;
        out_valid = state == MDU_DONE;
        busy      = !in_ready;
        state_nxt = (state == MDU_IDLE) ? (in_valid ? (fast ? MDU_DONE : MDU_BUSY) : MDU_IDLE) :
                    (state == MDU_BUSY) ? (cnt == '0 ? MDU_DONE : MDU_BUSY) :
                    (out_ready ? MDU_IDLE : MDU_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            op      <= MDU_MUL;
            neg     <= 1'b0;
            d       <= '0;
            prod    <= '0;
            mdu_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt  <= CW'(XLEN - 1);
                op   <= op_in;
                neg  <= neg_in;
                d    <= op_in[2] ? mag2 : mag1;
                prod <= {{XLEN{1'b0}}, op_in[2] ? mag1 : mag2};
                if (fast) mdu_out <= fast_res;
            end else if (state == MDU_BUSY) begin
                cnt  <= cnt - 1'b1;
                prod <= prod_nxt;
                if (cnt == '0) mdu_out <= result;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random checks of mdu against an arithmetic reference model
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_in1, mdu_in2, mdu_out;
    int          n_assert = 0;
    int          n_fail = 0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    mdu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_op    (mdu_op),
        .mdu_in1   (mdu_in1),
        .mdu_in2   (mdu_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mdu_out   (mdu_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = int'(a);
        longint      sb = int'(b);
        logic [63:0] p;
        case (op)
            MDU_MUL:    return a * b;
            MDU_MULH:   begin p = sa * sb;                     return p[63:32]; end
            MDU_MULHSU: begin p = sa * longint'(b);            return p[63:32]; end
            MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b};     return p[63:32]; end
            MDU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? MIN : 32'(int'(a) / int'(b));
            MDU_REM:    return (b == 0) ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(int'(a) % int'(b));
            MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 5);
        return (k == 0) ? 32'd0 : (k == 1) ? MIN : (k == 2) ? 32'hFFFF_FFFF :
               (k == 3) ? 32'($urandom_range(0, 15)) : 32'($urandom);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called #1 after the accept edge (cycle 1); returns the cycle in which out_valid is first seen
    task automatic wait_out(output int cyc, output logic held);
        cyc  = 1;
        held = 1'b1;
        while (!out_valid && cyc < 100) begin
            held &= !in_ready && busy;
            @(posedge clk); #1;
            cyc++;
        end
        held &= !in_ready && busy;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int   cyc;
        logic held;
        mdu_op    = op;
        mdu_in1   = a;
        mdu_in2   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mdu_op   = 3'($urandom);
        mdu_in1  = $urandom;
        mdu_in2  = $urandom;
        wait_out(cyc, held);
        check({tag, " latency"}, cyc, 33);
        check({tag, " stall"}, held, 1'b1);
        check({tag, " result"}, mdu_out, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        logic held;
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mdu_op = '0; mdu_in1 = '0; mdu_in2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset mdu_out", mdu_out, 32'd0);

        run_op(MDU_MUL,    32'd7,         32'd6,         32'd42,        "mul 7*6");
        run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu -1*-1");
        run_op(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh -1*-1");
        run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu -1*2");
        run_op(MDU_DIV,    -32'd20,       32'd3,         32'hFFFF_FFFA, "div -20/3");
        run_op(MDU_REM,    -32'd20,       32'd3,         32'hFFFF_FFFE, "rem -20/3");
        run_op(MDU_DIVU,   32'd20,        32'd3,         32'd6,         "divu 20/3");
        run_op(MDU_REMU,   32'd20,        32'd3,         32'd2,         "remu 20/3");
        run_op(MDU_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, "divu 100/0");
        run_op(MDU_REM,    32'd100,       32'd0,         32'd100,       "rem 100/0");
        run_op(MDU_DIV,    -32'd100,      32'd0,         32'hFFFF_FFFF, "div -100/0");
        run_op(MDU_DIV,    MIN,           32'hFFFF_FFFF, MIN,           "div overflow");
        run_op(MDU_REM,    MIN,           32'hFFFF_FFFF, 32'd0,         "rem overflow");

        // backpressure: result held for 5 cycles while a competing request is presented
        mdu_op = MDU_DIVU; mdu_in1 = 32'd20; mdu_in2 = 32'd3;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cyc, held);
        check("bp latency", cyc, 33);
        mdu_op = MDU_MUL; mdu_in1 = 32'd11; mdu_in2 = 32'd13; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid held", out_valid, 1'b1);
            check("bp mdu_out held", mdu_out, 32'd6);
            check("bp in_ready low", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; mdu_in1 = 32'd3; mdu_in2 = 32'd5;
        check("bp transfer out_valid", out_valid, 1'b1);
        check("bp transfer in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("bp idle in_ready", in_ready, 1'b1);
        check("bp idle out_valid", out_valid, 1'b0);
        check("bp idle mdu_out kept", mdu_out, 32'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp accepted busy", busy, 1'b1);
        wait_out(cyc, held);
        check("bp next latency", cyc, 33);
        check("bp next result", mdu_out, 32'd15);
        @(posedge clk); #1;

        // reset in BUSY cycle 10 drops the op
        mdu_op = MDU_MUL; mdu_in1 = 32'd1234; mdu_in2 = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("mid busy before rst", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst in_ready", in_ready, 1'b1);
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst mdu_out", mdu_out, 32'd0);
        check("mid rst busy", busy, 1'b0);
        run_op(MDU_MUL, 32'd3, 32'd5, 32'd15, "mul 3*5 after rst");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, ref_mdu(op, a, b), $sformatf("rand op%0d %0h,%0h", op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
